// File: rtl/axis_deadlock_block_detector.sv
// Filters transient AXIS/instance stalls; block asserts STABLE_CYCLES-1 edges after the first qualifying sample.
// Outputs are purely registered; no flow control of its own, it only observes the kernel's stall signals.
module axis_deadlock_block_detector #(
  parameter int NUM_AXIS      = 2,
  parameter int NUM_INST      = 1,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_INST-1:0] inst_idle_sigs,
  input  logic [NUM_INST-1:0] inst_block_sigs,
  output logic                block,
  output logic [NUM_AXIS-1:0] block_snapshot,
  output logic [CNT_W-1:0]    stall_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_BLOCKED
  } state_t;

  localparam logic [8:0]       STABLE_TGT = 9'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STALL_MAX  = '1;

  state_t              state, state_nxt;
  logic [7:0]          cnt, cnt_nxt;
  logic [NUM_AXIS-1:0] prev_pat;
  logic [NUM_AXIS-1:0] snap_nxt;
  logic [CNT_W-1:0]    stall_nxt;
  logic                candidate;
  logic                changed;
  logic                stable_hit;

  // A kernel with every instance idle is not running, so it can never be deadlocked.
  assign candidate  = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs);
  assign changed    = (axis_block_sigs != prev_pat);
  assign stable_hit = (({1'b0, cnt} + 9'd1) == STABLE_TGT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    snap_nxt  = block_snapshot;
    stall_nxt = stall_count;
    case (state)
      ST_IDLE: begin
        if (candidate) begin
          state_nxt = ST_COUNT;
          cnt_nxt   = 8'd1;
        end else begin
          cnt_nxt = '0;
        end
      end
      ST_COUNT: begin
        if (!candidate) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (changed) begin
          cnt_nxt = 8'd1;
        end else if (stable_hit) begin
          state_nxt = ST_BLOCKED;
          snap_nxt  = axis_block_sigs;
          stall_nxt = '0;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      ST_BLOCKED: begin
        if (!candidate) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (changed) begin
          state_nxt = ST_COUNT;
          cnt_nxt   = 8'd1;
        end else if (stall_count != STALL_MAX) begin
          stall_nxt = stall_count + 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      prev_pat       <= '0;
      block_snapshot <= '0;
      stall_count    <= '0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      prev_pat       <= axis_block_sigs;
      block_snapshot <= snap_nxt;
      stall_count    <= stall_nxt;
    end
  end

  assign block = (state == ST_BLOCKED);

endmodule

// File: tb/tb_axis_deadlock_block_detector.sv
module tb_axis_deadlock_block_detector;
  localparam int NUM_AXIS = 2;
  localparam int NUM_INST = 1;
  localparam int S        = 16;
  localparam int CNT_W    = 8;
  localparam int SAT      = (1 << CNT_W) - 1;

  logic                clock = 1'b0;
  logic                reset;
  logic [NUM_AXIS-1:0] axis_block_sigs;
  logic [NUM_INST-1:0] inst_idle_sigs;
  logic [NUM_INST-1:0] inst_block_sigs;
  logic                block;
  logic [NUM_AXIS-1:0] block_snapshot;
  logic [CNT_W-1:0]    stall_count;

  int n_checks = 0;
  int n_pass   = 0;

  axis_deadlock_block_detector #(
    .NUM_AXIS(NUM_AXIS), .NUM_INST(NUM_INST), .STABLE_CYCLES(S), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset), .axis_block_sigs(axis_block_sigs),
    .inst_idle_sigs(inst_idle_sigs), .inst_block_sigs(inst_block_sigs),
    .block(block), .block_snapshot(block_snapshot), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  // Reference: length of the current qualifying streak with an unchanged pattern.
  int                  m_run   = 0;
  logic [NUM_AXIS-1:0] m_prev  = '0;
  logic [NUM_AXIS-1:0] m_snap  = '0;
  int                  m_stall = 0;
  bit                  m_cand;

  always @(posedge clock) begin
    if (reset) begin
      m_run = 0; m_prev = '0; m_snap = '0; m_stall = 0;
    end else begin
      m_cand = (|axis_block_sigs || |inst_block_sigs) && !(&inst_idle_sigs);
      if (!m_cand) m_run = 0;
      else if (m_run == 0 || axis_block_sigs != m_prev) m_run = 1;
      else m_run = m_run + 1;
      if (m_run == S) begin
        m_snap  = axis_block_sigs;
        m_stall = 0;
      end else if (m_run > S && m_stall < SAT) begin
        m_stall = m_stall + 1;
      end
      m_prev = axis_block_sigs;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  bit chk_en = 1'b0;
  always @(negedge clock) begin
    if (chk_en) begin
      check("model_block", 32'(block), 32'(m_run >= S));
      check("model_snapshot", 32'(block_snapshot), 32'(m_snap));
      check("model_stall", 32'(stall_count), 32'(m_stall));
    end
  end

  task automatic hold(input logic [NUM_AXIS-1:0] a, input logic ii, input logic ib, input int n);
    axis_block_sigs = a;
    inst_idle_sigs  = ii;
    inst_block_sigs = ib;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  task automatic rst_pulse(input logic [NUM_AXIS-1:0] a);
    reset = 1'b1;
    hold(a, 1'b0, 1'b0, 1);
    reset = 1'b0;
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    check(name, act, exp);
  endtask

  initial begin
    int r;
    logic [NUM_AXIS-1:0] a;
    logic ii, ib;
    reset = 1'b1;
    chk_en = 1'b1;
    hold(2'b00, 1'b0, 1'b0, 2);
    reset = 1'b0;
    lit("reset_block", 32'(block), 0);
    lit("reset_snapshot", 32'(block_snapshot), 0);
    lit("reset_stall", 32'(stall_count), 0);

    // Constant 01: block rises on the 16th sample.
    hold(2'b01, 1'b0, 1'b0, 15);
    lit("t1_block_before", 32'(block), 0);
    hold(2'b01, 1'b0, 1'b0, 1);
    lit("t1_block_rise", 32'(block), 1);
    lit("t1_snapshot", 32'(block_snapshot), 32'h1);
    lit("t1_stall0", 32'(stall_count), 0);
    hold(2'b01, 1'b0, 1'b0, 1);
    lit("t1_stall1", 32'(stall_count), 1);
    hold(2'b01, 1'b0, 1'b0, 1);
    lit("t1_stall2", 32'(stall_count), 2);

    hold(2'b01, 1'b0, 1'b0, 300);
    lit("sat_stall", 32'(stall_count), 255);
    lit("sat_block", 32'(block), 1);

    // One-cycle release, then re-block.
    hold(2'b00, 1'b0, 1'b0, 1);
    lit("t4_block_fall", 32'(block), 0);
    lit("t4_stall_held", 32'(stall_count), 255);
    hold(2'b01, 1'b0, 1'b0, 15);
    lit("t4_block_before", 32'(block), 0);
    hold(2'b01, 1'b0, 1'b0, 1);
    lit("t4_block_rise", 32'(block), 1);
    lit("t4_snapshot", 32'(block_snapshot), 32'h1);
    lit("t4_stall_restart", 32'(stall_count), 0);

    // Reset while blocked.
    rst_pulse(2'b01);
    lit("rstb_block", 32'(block), 0);
    lit("rstb_snapshot", 32'(block_snapshot), 0);
    lit("rstb_stall", 32'(stall_count), 0);

    // Reset mid-count at cnt = 9, then counting restarts from 1.
    hold(2'b01, 1'b0, 1'b0, 9);
    rst_pulse(2'b01);
    lit("rstc_block", 32'(block), 0);
    hold(2'b01, 1'b0, 1'b0, 15);
    lit("rstc_block_before", 32'(block), 0);
    hold(2'b01, 1'b0, 1'b0, 1);
    lit("rstc_block_rise", 32'(block), 1);

    // Pattern change restarts the count.
    rst_pulse(2'b00);
    hold(2'b10, 1'b0, 1'b0, 10);
    hold(2'b11, 1'b0, 1'b0, 15);
    lit("t2_block_before", 32'(block), 0);
    hold(2'b11, 1'b0, 1'b0, 1);
    lit("t2_block_rise", 32'(block), 1);
    lit("t2_snapshot", 32'(block_snapshot), 32'h3);

    // All instances idle never qualifies.
    rst_pulse(2'b00);
    hold(2'b11, 1'b1, 1'b0, 40);
    lit("t3_block", 32'(block), 0);
    lit("t3_stall", 32'(stall_count), 0);

    // Random phase, biased toward long stable holds.
    a = 2'b01; ii = 1'b0; ib = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      r = $urandom_range(0, 999);
      if (r < 40) a = 2'($urandom_range(0, 3));
      else if (r < 55) ib = ~ib;
      else if (r < 65) ii = ~ii;
      reset = (r >= 995);
      hold(a, ii, ib, 1);
    end
    reset = 1'b0;
    hold(2'b00, 1'b0, 1'b0, 2);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
